// File: rtl/hex_capture_buffer.sv
// Byte-stream capture into a shadow buffer, published to the hex overlay vector on a display-sync rising edge.
// Optional macro HEX_CAPTURE_CLEAR_EN: zero the whole shadow at every capture start.
//
// state   | meaning
// IDLE    | waiting for an armed sof beat; other beats are accepted and dropped
// CAPTURE | writing bytes into the shadow at index count
// HOLD    | capture complete, waiting for display_sync rising edge to publish
module hex_capture_buffer #(
   parameter int c_data_len = 5120,
   parameter int c_cnt_bits = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  arm,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [7:0]            in_data,
   input  logic                  in_sof,
   input  logic                  in_eof,
   input  logic                  display_sync,
   output logic [c_data_len-1:0] data,
   output logic [c_cnt_bits-1:0] byte_count,
   output logic                  capture_done,
   output logic                  busy
);

   localparam int C_BYTES = c_data_len / 8;
   localparam logic [c_cnt_bits-1:0] LAST_IDX = c_cnt_bits'(C_BYTES - 1);
   localparam logic [c_cnt_bits-1:0] ONE      = c_cnt_bits'(1);
`ifdef HEX_CAPTURE_CLEAR_EN
   localparam bit CLEAR_EN = 1'b1;
`else
   localparam bit CLEAR_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      HOLD    = 2'd2
   } state_t;

   state_t                  state, state_next;
   logic [c_data_len-1:0]   shadow;
   logic [c_cnt_bits-1:0]   count, count_next;
   logic [c_cnt_bits-1:0]   wr_idx;
   logic                    wr_en;
   logic                    start;
   logic                    go_hold;
   logic                    publish;
   logic                    sync_q;
   logic                    accept;
   logic                    sync_rise;

   assign in_ready  = (state != HOLD);
   assign busy      = (state != IDLE);
   assign accept    = in_valid && in_ready;
   assign sync_rise = display_sync && !sync_q;

   always_comb begin
      state_next = state;
      count_next = count;
      wr_en      = 1'b0;
      wr_idx     = '0;
      start      = 1'b0;
      go_hold    = 1'b0;
      publish    = 1'b0;
      case (state)
         IDLE: begin
            if (accept && in_sof && arm) begin
               wr_en      = 1'b1;
               start      = 1'b1;
               count_next = ONE;
               go_hold    = in_eof || (C_BYTES == 1);
               state_next = CAPTURE;
            end
         end
         CAPTURE: begin
            if (accept) begin
               wr_en = 1'b1;
               if (in_sof) begin
                  // restart: sof takes priority over the length limit
                  start      = 1'b1;
                  count_next = ONE;
                  go_hold    = in_eof;
               end else begin
                  wr_idx     = count;
                  count_next = count + ONE;
                  go_hold    = in_eof || (count == LAST_IDX);
               end
            end
         end
         HOLD: begin
            if (sync_rise) begin
               publish    = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
      if (go_hold) state_next = HOLD;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         count        <= '0;
         shadow       <= '0;
         data         <= '0;
         byte_count   <= '0;
         capture_done <= 1'b0;
         sync_q       <= 1'b0;
      end else begin
         state        <= state_next;
         count        <= count_next;
         capture_done <= go_hold;
         sync_q       <= display_sync;
         if (wr_en) begin
            if (start && CLEAR_EN) shadow <= '0;
            // nibble swap so the renderer shows the high nibble first
            shadow[{wr_idx, 3'b000} +: 8] <= {in_data[3:0], in_data[7:4]};
         end
         if (publish) begin
            data       <= shadow;
            byte_count <= count;
         end
      end
   end

endmodule

// File: doc/hex_capture_buffer.md
# hex_capture_buffer

Producer side of the on-screen hex debug overlay: captures a byte stream (e.g. a packet header or line sample from the MIPI CSI-2 receiver) into a flat bit vector laid out for the hex overlay renderer. Bytes are collected into a shadow buffer and published to the display vector only on a display frame-sync rising edge, so the screen never shows a half-written capture. Sits between the receiver's byte stream and the overlay's `data` input.

## Interface

Parameters:
- `c_data_len`, 5120, width of published vector in bits; must be a multiple of 8; C_BYTES = c_data_len/8
- `c_cnt_bits`, 10, byte counter width; must satisfy 2^c_cnt_bits > C_BYTES

Ports:
- `clk`  in  1  single clock for all logic
- `rst_n`  in  1  asynchronous, active-low reset
- `arm`  in  1  level; permits a new capture to start
- `in_valid`  in  1  byte beat valid
- `in_ready`  out  1  byte beat accepted when `in_valid && in_ready`
- `in_data`  in  8  byte payload
- `in_sof`  in  1  qualifies beat as first byte of a capture
- `in_eof`  in  1  qualifies beat as last byte of a capture
- `display_sync`  in  1  frame sync from display timing, synchronous to `clk`
- `data`  out  c_data_len  published vector, feeds overlay renderer
- `byte_count`  out  c_cnt_bits  number of valid bytes in the published capture
- `capture_done`  out  1  one-cycle pulse when a capture completes (enters HOLD)
- `busy`  out  1  high in CAPTURE or HOLD

## Operation

- States: IDLE, CAPTURE, HOLD. Reset -> IDLE.
- `in_ready` = 1 in IDLE and CAPTURE, 0 in HOLD (combinational from state).
- IDLE: accepted beats without (`in_sof && arm`) are discarded. Beat with `in_sof && arm`: write byte 0, count=1, go CAPTURE; with `in_eof` also set, go HOLD directly.
- CAPTURE: each accepted beat writes byte at index count, count+1. `in_sof` restarts: byte written at index 0, count=1 (sof wins over any other condition). Transition to HOLD on a beat with `in_eof` or when the written index is C_BYTES-1.
- HOLD: no beats accepted. On `display_sync` rising edge (current 1, previously sampled 0): `data` <= shadow, `byte_count` <= count, go IDLE.
- Byte placement: byte k occupies shadow[8k+7:8k] with nibbles swapped: shadow[8k+3:8k] = in_data[7:4], shadow[8k+7:8k+4] = in_data[3:0], so digits render most-significant nibble first, left to right.
- Bytes beyond count keep prior shadow content unless cleared (see Configuration).
- `arm` is sampled only at sof in IDLE; deasserting mid-capture has no effect.

## Timing

- Reset values: `data`=0, shadow=0, `byte_count`=0, `capture_done`=0, `busy`=0, `in_ready`=1, sync history=0, state IDLE.
- Beat accepted at edge N -> shadow updated at N; state change visible after N. `in_ready` drops in the cycle after the completing beat.
- `capture_done` high exactly the cycle after the completing beat.
- Publish: edge where rising `display_sync` is sampled in HOLD; `data`/`byte_count` change after that edge; `in_ready` returns to 1 same cycle.
- A sync edge sampled in the same cycle as the completing beat (state still CAPTURE) does not publish; next edge does.
- Async reset in any state returns all registers to reset values immediately; partial captures are lost.
- Count never exceeds C_BYTES; no wrap-around.

## Configuration

- `HEX_CAPTURE_CLEAR_EN` defined: on each capture start (sof beat in IDLE or restart in CAPTURE) the whole shadow is zeroed in the same cycle before byte 0 is written; unwritten bytes publish as 0.
- Not defined: shadow is never cleared after reset; bytes beyond count retain previous capture content.

## Test plan

(c_data_len=64, C_BYTES=8)
- Reset mid-HOLD -> `data`=0, `byte_count`=0, `in_ready`=1, `busy`=0 immediately.
- arm=1; beats 0xAB(sof), 0x12, 0x34(eof) -> `capture_done` pulse, `in_ready`=0; sync pulse -> `data`[23:0]=0x4321BA, `byte_count`=3.
- 10 beats with sof on first, no eof -> HOLD after 8th, 9th held (in_ready=0); after sync `byte_count`=8, data=bytes 0..7.
- sof on 3rd beat of capture -> restart; published bytes start at the 3rd beat's value.
- arm=0; sof/eof beats -> all accepted and discarded, `busy`=0, `data` unchanged after sync.
- 4-byte capture then 2-byte capture -> bytes 2..3 are 0 with `HEX_CAPTURE_CLEAR_EN`, old values without.
